// File: rtl/fb_swap_scheduler.sv
// Framebuffer swap scheduler.
// Holds one pending commit from the renderer and hands buffers to the
// framebuffer reader on vsync (or immediately when WAIT_VSYNC is 0). It can
// re-stream the front buffer when nothing new is pending, and it counts
// vsync pulses that could not be serviced.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | waiting for a start condition (pending commit or refresh)
// REQ       | swap_fb just raised, fb_addr/fb_size loaded
// WAIT_LOW  | swap_fb held high until the reader drops fb_swapped
// WAIT_HIGH | transfer in progress, waiting for fb_swapped to return high
module fb_swap_scheduler #(
  parameter int ADDR_WIDTH          = 32,
  parameter int FB_SIZE_IN_PIXEL_LG = 20,
  parameter int WAIT_VSYNC          = 1
) (
  input  logic                           aclk,
  input  logic                           resetn,
  input  logic                           s_req_valid,
  output logic                           s_req_ready,
  input  logic [ADDR_WIDTH-1:0]          s_req_addr,
  input  logic [FB_SIZE_IN_PIXEL_LG-1:0] s_req_size,
  input  logic                           vsync,
  input  logic                           refresh_en,
  output logic                           swap_fb,
  output logic [ADDR_WIDTH-1:0]          fb_addr,
  output logic [FB_SIZE_IN_PIXEL_LG-1:0] fb_size,
  input  logic                           fb_swapped,
  output logic [ADDR_WIDTH-1:0]          front_addr,
  output logic                           busy,
  output logic                           done,
  output logic [7:0]                     overrun_cnt
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQ       = 2'd1,
    WAIT_LOW  = 2'd2,
    WAIT_HIGH = 2'd3
  } state_t;

  state_t                           state_q, state_d;
  logic                             swap_q, swap_d;
  logic [ADDR_WIDTH-1:0]            fb_addr_q, fb_addr_d;
  logic [FB_SIZE_IN_PIXEL_LG-1:0]   fb_size_q, fb_size_d;
  logic [ADDR_WIDTH-1:0]            front_addr_q, front_addr_d;
  logic [FB_SIZE_IN_PIXEL_LG-1:0]   front_size_q, front_size_d;
  logic                             front_valid_q, front_valid_d;
  logic [ADDR_WIDTH-1:0]            pend_addr_q, pend_addr_d;
  logic [FB_SIZE_IN_PIXEL_LG-1:0]   pend_size_q, pend_size_d;
  logic                             pend_valid_q, pend_valid_d;
  logic                             done_q, done_d;
  logic [7:0]                       ovr_q, ovr_d;

  logic want_start;
  logic accept;

  // Start condition ignoring reader readiness; a commit accepted this cycle
  // is not yet visible in pend_valid_q, so it cannot be used by this vsync.
  always_comb begin
    want_start = 1'b0;
    if (pend_valid_q) begin
      want_start = vsync || (WAIT_VSYNC == 0);
    end else begin
      want_start = refresh_en && front_valid_q && vsync;
    end
  end

  assign accept = s_req_valid && !pend_valid_q;

  // Next-state, pending register, outputs and overrun accounting.
  always_comb begin
    state_d       = state_q;
    swap_d        = swap_q;
    fb_addr_d     = fb_addr_q;
    fb_size_d     = fb_size_q;
    front_addr_d  = front_addr_q;
    front_size_d  = front_size_q;
    front_valid_d = front_valid_q;
    pend_addr_d   = pend_addr_q;
    pend_size_d   = pend_size_q;
    pend_valid_d  = pend_valid_q;
    done_d        = 1'b0;
    ovr_d         = ovr_q;

    if (accept) begin
      pend_valid_d = 1'b1;
      pend_addr_d  = s_req_addr;
      pend_size_d  = s_req_size;
    end

    // A vsync is missed when busy, or when idle but the reader is not ready.
    if (vsync && ((state_q != IDLE) || (want_start && !fb_swapped))) begin
      if (ovr_q != 8'hFF) ovr_d = ovr_q + 8'd1;
    end

    case (state_q)
      IDLE: begin
        if (want_start && fb_swapped) begin
          state_d = REQ;
          swap_d  = 1'b1;
          if (pend_valid_q) begin
            fb_addr_d    = pend_addr_q;
            fb_size_d    = pend_size_q;
            pend_valid_d = 1'b0;
          end else begin
            fb_addr_d = front_addr_q;
            fb_size_d = front_size_q;
          end
        end
      end
      REQ: begin
        state_d = WAIT_LOW;
      end
      WAIT_LOW: begin
        if (!fb_swapped) begin
          swap_d  = 1'b0;
          state_d = WAIT_HIGH;
        end
      end
      WAIT_HIGH: begin
        if (fb_swapped) begin
          done_d        = 1'b1;
          front_addr_d  = fb_addr_q;
          front_size_d  = fb_size_q;
          front_valid_d = 1'b1;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= IDLE;
      swap_q        <= 1'b0;
      fb_addr_q     <= '0;
      fb_size_q     <= '0;
      front_addr_q  <= '0;
      front_size_q  <= '0;
      front_valid_q <= 1'b0;
      pend_addr_q   <= '0;
      pend_size_q   <= '0;
      pend_valid_q  <= 1'b0;
      done_q        <= 1'b0;
      ovr_q         <= 8'd0;
    end else begin
      state_q       <= state_d;
      swap_q        <= swap_d;
      fb_addr_q     <= fb_addr_d;
      fb_size_q     <= fb_size_d;
      front_addr_q  <= front_addr_d;
      front_size_q  <= front_size_d;
      front_valid_q <= front_valid_d;
      pend_addr_q   <= pend_addr_d;
      pend_size_q   <= pend_size_d;
      pend_valid_q  <= pend_valid_d;
      done_q        <= done_d;
      ovr_q         <= ovr_d;
    end
  end

  assign s_req_ready = !pend_valid_q;
  assign swap_fb     = swap_q;
  assign fb_addr     = fb_addr_q;
  assign fb_size     = fb_size_q;
  assign front_addr  = front_addr_q;
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign overrun_cnt = ovr_q;

endmodule

// File: tb/tb_fb_swap_scheduler.sv
// Directed bench for fb_swap_scheduler: one instance waits for vsync, a
// second instance starts swaps as soon as possible.
module tb_fb_swap_scheduler;

  logic        aclk = 1'b0;
  logic        resetn = 1'b0;

  logic        vld = 1'b0, vs = 1'b0, rf = 1'b0, fbs = 1'b1;
  logic [31:0] addr = '0;
  logic [19:0] size = '0;
  logic        rdy, swp, bsy, dn;
  logic [31:0] fa, front;
  logic [19:0] fs;
  logic [7:0]  ovr;

  logic        vld0 = 1'b0, vs0 = 1'b0, rf0 = 1'b0, fbs0 = 1'b1;
  logic [31:0] addr0 = '0;
  logic [19:0] size0 = '0;
  logic        rdy0, swp0, bsy0, dn0;
  logic [31:0] fa0, front0;
  logic [19:0] fs0;
  logic [7:0]  ovr0;

  int total = 0;
  int bad = 0;

  always #5 aclk = ~aclk;

  fb_swap_scheduler #(.ADDR_WIDTH(32), .FB_SIZE_IN_PIXEL_LG(20), .WAIT_VSYNC(1)) dut1 (
    .aclk(aclk), .resetn(resetn), .s_req_valid(vld), .s_req_ready(rdy),
    .s_req_addr(addr), .s_req_size(size), .vsync(vs), .refresh_en(rf),
    .swap_fb(swp), .fb_addr(fa), .fb_size(fs), .fb_swapped(fbs),
    .front_addr(front), .busy(bsy), .done(dn), .overrun_cnt(ovr));

  fb_swap_scheduler #(.ADDR_WIDTH(32), .FB_SIZE_IN_PIXEL_LG(20), .WAIT_VSYNC(0)) dut0 (
    .aclk(aclk), .resetn(resetn), .s_req_valid(vld0), .s_req_ready(rdy0),
    .s_req_addr(addr0), .s_req_size(size0), .vsync(vs0), .refresh_en(rf0),
    .swap_fb(swp0), .fb_addr(fa0), .fb_size(fs0), .fb_swapped(fbs0),
    .front_addr(front0), .busy(bsy0), .done(dn0), .overrun_cnt(ovr0));

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One complete frame on dut1 started by a vsync while idle.
  task automatic run_frame(input string tag, input logic [31:0] exp_addr);
    vs = 1'b1;
    tick();
    chk({tag, "_swap_hi"}, swp, 1);
    chk({tag, "_fb_addr"}, fa, exp_addr);
    vs = 1'b0;
    tick();
    chk({tag, "_swap_hold"}, swp, 1);
    fbs = 1'b0;
    tick();
    chk({tag, "_swap_lo"}, swp, 0);
    chk({tag, "_busy"}, bsy, 1);
    fbs = 1'b1;
    tick();
    chk({tag, "_done"}, dn, 1);
    chk({tag, "_front"}, front, exp_addr);
    chk({tag, "_idle"}, bsy, 0);
    tick();
    chk({tag, "_done_1cyc"}, dn, 0);
  endtask

  initial begin
    // reset values
    #12;
    chk("rst_swap", swp, 0);
    chk("rst_fb_addr", fa, 0);
    chk("rst_fb_size", fs, 0);
    chk("rst_front", front, 0);
    chk("rst_ready", rdy, 1);
    chk("rst_busy", bsy, 0);
    chk("rst_done", dn, 0);
    chk("rst_ovr", ovr, 0);
    #10 resetn = 1'b1;
    tick();

    // commit waits for vsync
    vld = 1'b1; addr = 32'h1000; size = 20'h4B000;
    tick();
    chk("c1_ready_lo", rdy, 0);
    chk("c1_no_swap", swp, 0);
    vld = 1'b0;
    tick();
    tick();
    chk("c1_still_no_swap", swp, 0);
    chk("c1_still_idle", bsy, 0);
    vs = 1'b1;
    tick();
    chk("c1_swap_hi", swp, 1);
    chk("c1_fb_addr", fa, 32'h1000);
    chk("c1_fb_size", fs, 20'h4B000);
    chk("c1_ready_back", rdy, 1);
    chk("c1_busy", bsy, 1);
    vs = 1'b0;
    tick();
    chk("c1_wait_low_swap", swp, 1);
    fbs = 1'b0;
    tick();
    chk("c1_swap_lo", swp, 0);
    tick();
    chk("c1_wait_high_swap", swp, 0);
    chk("c1_wait_high_busy", bsy, 1);
    fbs = 1'b1;
    tick();
    chk("c1_done", dn, 1);
    chk("c1_front", front, 32'h1000);
    chk("c1_idle", bsy, 0);
    tick();
    chk("c1_done_1cyc", dn, 0);
    chk("c1_ovr", ovr, 0);

    // refresh re-streams the front buffer every vsync
    rf = 1'b1;
    run_frame("rf1", 32'h1000);
    run_frame("rf2", 32'h1000);
    rf = 1'b0;
    vs = 1'b1;
    tick();
    chk("rf_off_no_swap", swp, 0);
    vs = 1'b0;
    tick();
    chk("rf_off_ovr", ovr, 0);

    // second commit stalls while the first is pending
    rf = 1'b1;
    vs = 1'b1;
    tick();
    vs = 1'b0;
    tick();
    fbs = 1'b0;
    tick();
    vld = 1'b1; addr = 32'h2000; size = 20'h10;
    tick();
    chk("c2_accept", rdy, 0);
    addr = 32'h3000; size = 20'h20;
    tick();
    chk("c3_stall", rdy, 0);
    fbs = 1'b1;
    tick();
    chk("c2_prev_done", dn, 1);
    chk("c2_prev_front", front, 32'h1000);
    vs = 1'b1;
    tick();
    chk("c2_swap", swp, 1);
    chk("c2_fb_addr", fa, 32'h2000);
    chk("c2_fb_size", fs, 20'h10);
    chk("c3_slot_free", rdy, 1);
    vs = 1'b0;
    tick();
    chk("c3_accept", rdy, 0);
    vld = 1'b0;
    fbs = 1'b0;
    tick();
    fbs = 1'b1;
    tick();
    chk("c2_done", dn, 1);
    chk("c2_front", front, 32'h2000);
    tick();
    run_frame("c3", 32'h3000);
    rf = 1'b0;
    chk("c_ovr_zero", ovr, 0);

    // missed vsync counting and saturation
    rf = 1'b1;
    vs = 1'b1;
    tick();
    vs = 1'b0;
    tick();
    fbs = 1'b0;
    tick();
    rf = 1'b0;
    repeat (3) begin
      vs = 1'b1; tick();
      vs = 1'b0; tick();
    end
    chk("ovr_3", ovr, 3);
    repeat (251) begin
      vs = 1'b1; tick();
      vs = 1'b0; tick();
    end
    chk("ovr_254", ovr, 254);
    repeat (46) begin
      vs = 1'b1; tick();
      vs = 1'b0; tick();
    end
    chk("ovr_sat", ovr, 255);
    chk("ovr_still_busy", bsy, 1);
    vld = 1'b1; addr = 32'h4000; size = 20'h40;
    tick();
    chk("r_pending", rdy, 0);
    vld = 1'b0;

    // asynchronous reset in the middle of a transfer
    #2 resetn = 1'b0;
    #1;
    chk("ar_swap", swp, 0);
    chk("ar_busy", bsy, 0);
    chk("ar_fb_addr", fa, 0);
    chk("ar_front", front, 0);
    chk("ar_ovr", ovr, 0);
    chk("ar_ready", rdy, 1);
    chk("ar_done", dn, 0);
    tick();
    tick();
    resetn = 1'b1;
    rf = 1'b1;
    vs = 1'b1;
    tick();
    chk("ar_no_front_no_swap", swp, 0);
    chk("ar_no_front_ovr", ovr, 0);
    vs = 1'b0;
    vld = 1'b1; addr = 32'h5000; size = 20'h77;
    tick();
    chk("ar_commit", rdy, 0);
    vld = 1'b0;
    vs = 1'b1;
    tick();
    chk("idle_rdr_busy_ovr", ovr, 1);
    chk("idle_rdr_busy_swap", swp, 0);
    chk("idle_rdr_busy_idle", bsy, 0);
    vs = 1'b0;
    fbs = 1'b1;
    tick();
    chk("ar_wait_vsync", swp, 0);
    run_frame("ar", 32'h5000);
    rf = 1'b0;

    // WAIT_VSYNC=0 instance: start on the cycle after the commit lands
    vld0 = 1'b1; addr0 = 32'hA000; size0 = 20'h123;
    tick();
    chk("nv_accept", rdy0, 0);
    chk("nv_no_swap_yet", swp0, 0);
    vld0 = 1'b0;
    tick();
    chk("nv_swap", swp0, 1);
    chk("nv_fb_addr", fa0, 32'hA000);
    chk("nv_fb_size", fs0, 20'h123);
    tick();
    chk("nv_swap_hold", swp0, 1);
    chk("nv_addr_stable1", fa0, 32'hA000);
    fbs0 = 1'b0;
    tick();
    chk("nv_swap_lo", swp0, 0);
    chk("nv_addr_stable2", fa0, 32'hA000);
    chk("nv_size_stable2", fs0, 20'h123);
    fbs0 = 1'b1;
    tick();
    chk("nv_done", dn0, 1);
    chk("nv_front", front0, 32'hA000);
    chk("nv_size_stable3", fs0, 20'h123);
    chk("nv_idle", bsy0, 0);
    tick();
    chk("nv_done_1cyc", dn0, 0);
    chk("nv_no_restart", swp0, 0);
    chk("nv_ovr", ovr0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
